stream_arbiter_unit: RTL and testbench

Per-output packet arbiter for the stream crossbar. For each master (output) port it collects requests from all slave (input) streams addressed to it, selects one winner, and holds that grant for a whole packet until the final beat is accepted. It sits directly upstream of the data communication net: its `grant_o` and `arbiter_ready_o` buses drive that stage's `grant_i` and `arbiter_ready_i` inputs, bit for bit and element for element.

---
 rtl/stream_xbar_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 116 +++++++++++
 rtl/stream_arbiter_unit.sv | 60 ++++++
 tb/tb_stream_arbiter_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_xbar_pkg.sv
// stream_xbar_pkg: definitions shared by the stream crossbar arbiter files.
//   arb_state_t - per-output arbiter FSM state
//   id_width    - width of an input-stream (grant) index
//   dest_width  - width of an output-stream (destination) index
package stream_xbar_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic int id_width(input int s_count);
        return $clog2(s_count);
    endfunction

    function automatic int dest_width(input int m_count);
        return $clog2(m_count);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: packet arbiter for a single output port.
// Picks one requesting input while idle and keeps that grant locked until
// the winner's last beat is accepted by the output.
// Configuration macro: STREAM_ARB_ROUND_ROBIN_EN
//   defined   - round-robin search starting at a rotating pointer
//   undefined - fixed priority, lowest requesting index wins (no pointer)
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   req    in  S  per-input request addressed to this output
//   last   in  S  per-input last-beat flag
//   ready  in  1  this output accepts a beat
//   grant  out W  registered index of the owning input
//   busy   out 1  grant is valid and locked
module rr_arbiter
    import stream_xbar_pkg::*;
#(
    parameter  int S_DATA_COUNT = 2,
    localparam int T_ID___WIDTH = id_width(S_DATA_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [S_DATA_COUNT-1:0] req,
    input  logic [S_DATA_COUNT-1:0] last,
    input  logic                    ready,
    output logic [T_ID___WIDTH-1:0] grant,
    output logic                    busy
);

    localparam int unsigned             S_N     = S_DATA_COUNT;
    localparam logic [T_ID___WIDTH-1:0] LAST_ID = T_ID___WIDTH'(S_DATA_COUNT - 1);

    arb_state_t              state_q, state_d;
    logic [T_ID___WIDTH-1:0] grant_q, grant_d;
    logic [T_ID___WIDTH-1:0] winner;
    logic                    pkt_done;

    // req already includes the destination match, so this is the full
    // valid && last && ready && dest==this-output handshake of the owner.
    assign pkt_done = req[grant_q] && last[grant_q] && ready;

`ifdef STREAM_ARB_ROUND_ROBIN_EN
    logic [T_ID___WIDTH-1:0] ptr_q, ptr_d;
    int unsigned             dist;
    int unsigned             best;

    // Winner is the requester at the smallest wrapped distance from ptr.
    always_comb begin
        winner = '0;
        best   = S_N;
        dist   = 0;
        for (int unsigned i = 0; i < S_N; i++) begin
            dist = (i >= 32'(ptr_q)) ? i - 32'(ptr_q) : i + S_N - 32'(ptr_q);
            if (req[i] && dist < best) begin
                best   = dist;
                winner = T_ID___WIDTH'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB_BUSY && pkt_done)
            ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < S_N; i++) begin
            if (req[i] && !found) begin
                found  = 1'b1;
                winner = T_ID___WIDTH'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    grant_d = winner;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (pkt_done) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ARB_BUSY);

endmodule

// File: rtl/stream_arbiter_unit.sv
// stream_arbiter_unit: per-output packet arbiters for the stream crossbar.
// Builds one request vector per output from the input destinations and
// instantiates one rr_arbiter per output.
// Configuration macro: STREAM_ARB_ROUND_ROBIN_EN (round-robin when defined,
// fixed lowest-index priority otherwise).
// Ports:
//   clk_i            in  1                 rising-edge clock
//   rst_in           in  1                 asynchronous active-low reset
//   s_dest_i         in  [DEST] x S        destination of each input
//   s_valid_i        in  S                 input beat valid
//   s_last_i         in  S                 input beat is last of packet
//   m_ready_i        in  M                 output accepts a beat
//   grant_o          out [ID] x M          input owning each output
//   arbiter_ready_o  out M                 grant valid and locked
module stream_arbiter_unit
    import stream_xbar_pkg::*;
#(
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_ID___WIDTH = id_width(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT)
) (
    input  logic                    clk_i,
    input  logic                    rst_in,
    input  logic [T_DEST_WIDTH-1:0] s_dest_i        [S_DATA_COUNT],
    input  logic [S_DATA_COUNT-1:0] s_valid_i,
    input  logic [S_DATA_COUNT-1:0] s_last_i,
    input  logic [M_DATA_COUNT-1:0] m_ready_i,
    output logic [T_ID___WIDTH-1:0] grant_o         [M_DATA_COUNT],
    output logic [M_DATA_COUNT-1:0] arbiter_ready_o
);

    localparam int unsigned S_N = S_DATA_COUNT;
    localparam int unsigned M_N = M_DATA_COUNT;

    logic [S_DATA_COUNT-1:0] req [M_DATA_COUNT];

    always_comb begin
        for (int unsigned j = 0; j < M_N; j++) begin
            for (int unsigned i = 0; i < S_N; i++) begin
                req[j][i] = s_valid_i[i] && (s_dest_i[i] == T_DEST_WIDTH'(j));
            end
        end
    end

    for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_out
        rr_arbiter #(
            .S_DATA_COUNT(S_DATA_COUNT)
        ) u_arb (
            .clk   (clk_i),
            .rst_n (rst_in),
            .req   (req[j]),
            .last  (s_last_i),
            .ready (m_ready_i[j]),
            .grant (grant_o[j]),
            .busy  (arbiter_ready_o[j])
        );
    end

endmodule

// File: tb/tb_stream_arbiter_unit.sv
// tb_stream_arbiter_unit: directed and randomized stimulus for
// stream_arbiter_unit (S=2, M=3), checked against a packet-level model.
// Honors STREAM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_stream_arbiter_unit;

    localparam int S  = 2;
    localparam int M  = 3;
    localparam int IW = 1;
    localparam int DW = 2;

`ifdef STREAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_in;
    logic [DW-1:0] s_dest_i [S];
    logic [S-1:0]  s_valid_i;
    logic [S-1:0]  s_last_i;
    logic [M-1:0]  m_ready_i;
    logic [IW-1:0] grant_o [M];
    logic [M-1:0]  arbiter_ready_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per output, whether a packet owns it, who, and the
    // round-robin start index.
    bit m_busy  [M];
    int m_grant [M];
    int m_ptr   [M];

    always #5 clk_i = ~clk_i;

    stream_arbiter_unit #(
        .S_DATA_COUNT(S),
        .M_DATA_COUNT(M)
    ) dut (
        .clk_i           (clk_i),
        .rst_in          (rst_in),
        .s_dest_i        (s_dest_i),
        .s_valid_i       (s_valid_i),
        .s_last_i        (s_last_i),
        .m_ready_i       (m_ready_i),
        .grant_o         (grant_o),
        .arbiter_ready_o (arbiter_ready_o)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic model_reset();
        for (int j = 0; j < M; j++) begin
            m_busy[j]  = 1'b0;
            m_grant[j] = 0;
            m_ptr[j]   = 0;
        end
    endtask

    // One clock of the arbitration rules, using the inputs seen at the edge.
    task automatic model_step();
        for (int j = 0; j < M; j++) begin
            if (!m_busy[j]) begin
                int w;
                w = -1;
                for (int k = 0; k < S; k++) begin
                    int i;
                    i = RR ? (m_ptr[j] + k) % S : k;
                    if (w < 0 && s_valid_i[i] && int'(s_dest_i[i]) == j) w = i;
                end
                if (w >= 0) begin
                    m_busy[j]  = 1'b1;
                    m_grant[j] = w;
                end
            end else begin
                int g;
                g = m_grant[j];
                if (s_valid_i[g] && s_last_i[g] && m_ready_i[j] && int'(s_dest_i[g]) == j) begin
                    m_busy[j] = 1'b0;
                    if (RR) m_ptr[j] = (g + 1) % S;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int j = 0; j < M; j++) begin
            check($sformatf("rdy[%0d]", j), int'(arbiter_ready_o[j]), int'(m_busy[j]));
            check($sformatf("gnt[%0d]", j), int'(grant_o[j]), m_grant[j]);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l,
                         input int d0, input int d1, input logic [2:0] r);
        s_valid_i   = v;
        s_last_i    = l;
        s_dest_i[0] = DW'(d0);
        s_dest_i[1] = DW'(d1);
        m_ready_i   = r;
    endtask

    initial begin
        int exp_seq [3];

        rst_in = 1'b0;
        drive(2'b00, 2'b00, 0, 0, 3'b000);
        model_reset();
        #12;
        for (int j = 0; j < M; j++) begin
            check("reset_rdy", int'(arbiter_ready_o[j]), 0);
            check("reset_gnt", int'(grant_o[j]), 0);
        end
        @(posedge clk_i);
        #1;
        rst_in = 1'b1;
        tick();

        // 3-beat packet from input 0 to output 1
        drive(2'b01, 2'b00, 1, 0, 3'b010);
        tick();
        check("s1_grant_rdy", int'(arbiter_ready_o[1]), 1);
        check("s1_grant_id", int'(grant_o[1]), 0);
        tick();
        tick();
        drive(2'b01, 2'b01, 1, 0, 3'b010);
        tick();
        check("s1_release", int'(arbiter_ready_o[1]), 0);
        drive(2'b00, 2'b00, 0, 0, 3'b111);
        tick();

        // both inputs contend for output 2 with single-beat packets
        exp_seq[0] = 0;
        exp_seq[1] = RR ? 1 : 0;
        exp_seq[2] = 0;
        drive(2'b11, 2'b11, 2, 2, 3'b111);
        for (int p = 0; p < 3; p++) begin
            tick();
            check("s2_busy", int'(arbiter_ready_o[2]), 1);
            check("s2_winner", int'(grant_o[2]), exp_seq[p]);
            tick();
            check("s2_idle_gap", int'(arbiter_ready_o[2]), 0);
        end
        drive(2'b00, 2'b00, 0, 0, 3'b111);
        tick();

        // input 1 stalled mid-packet while input 0 waits for the same output
        drive(2'b10, 2'b00, 1, 1, 3'b000);
        tick();
        check("s3_owner", int'(grant_o[1]), 1);
        drive(2'b11, 2'b00, 1, 1, 3'b000);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("s3_hold", int'(grant_o[1]), 1);
            check("s3_hold_rdy", int'(arbiter_ready_o[1]), 1);
        end
        drive(2'b11, 2'b10, 1, 1, 3'b010);
        tick();
        check("s3_release", int'(arbiter_ready_o[1]), 0);
        drive(2'b01, 2'b00, 1, 1, 3'b010);
        tick();
        check("s3_next_owner", int'(grant_o[1]), 0);
        drive(2'b01, 2'b01, 1, 1, 3'b010);
        tick();
        drive(2'b00, 2'b00, 0, 0, 3'b111);
        tick();

        // independent outputs granted in the same cycle
        drive(2'b11, 2'b00, 0, 2, 3'b111);
        tick();
        check("s4_rdy0", int'(arbiter_ready_o[0]), 1);
        check("s4_rdy2", int'(arbiter_ready_o[2]), 1);
        check("s4_gnt0", int'(grant_o[0]), 0);
        check("s4_gnt2", int'(grant_o[2]), 1);

        // asynchronous reset mid-packet, away from any clock edge
        #2;
        rst_in = 1'b0;
        #1;
        check("s5_async_rdy", int'(arbiter_ready_o), 0);
        check("s5_async_gnt2", int'(grant_o[2]), 0);
        model_reset();
        @(posedge clk_i);
        #1;
        check("s5_held_rdy", int'(arbiter_ready_o), 0);
        rst_in = 1'b1;
        tick();
        check("s5_regrant0", int'(arbiter_ready_o[0]), 1);
        check("s5_regrant2", int'(grant_o[2]), 1);
        drive(2'b11, 2'b11, 0, 2, 3'b111);
        tick();
        drive(2'b00, 2'b00, 0, 0, 3'b111);
        tick();

        // single-beat packet
        drive(2'b01, 2'b01, 1, 0, 3'b111);
        tick();
        check("s6_busy", int'(arbiter_ready_o[1]), 1);
        tick();
        check("s6_one_cycle", int'(arbiter_ready_o[1]), 0);
        drive(2'b00, 2'b00, 0, 0, 3'b111);
        tick();
        check("s6_stays_idle", int'(arbiter_ready_o[1]), 0);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            drive(2'($urandom),
                  {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                  int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                  3'($urandom | $urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
